lo_prescaler: RTL
=================

LO_PRESCALER -- requirements
Module: lo_prescaler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the divide ratio.
REQ-002 SHALL have parameter RESET_DIV, default 4: divide ratio after reset; legal range 2..2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock (master reference clock).
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1 bit: serial configuration clock, asynchronous to clk.
REQ-006 SHALL have port sdata, input, 1 bit: serial ratio data, MSB first, asynchronous to clk.
REQ-007 SHALL have port sload, input, 1 bit: latch strobe, asynchronous to clk.
REQ-008 SHALL have port lo_out, output, 1 bit: divided clock that drives the quadrature divider clock input.
REQ-009 SHALL have port tc, output, 1 bit: one-cycle terminal-count pulse.
REQ-010 SHALL have port pend, output, 1 bit: new ratio latched but not yet applied.

Function
REQ-011 SHALL pass sclk, sdata and sload each through a 2-flop synchronizer plus one history flop; an event is synchronized level 1 with history 0.
REQ-012 SHALL, on each sclk event, shift synchronized sdata into the LSB of a WIDTH-bit shift register (MSB-first load).
REQ-013 SHALL, on each sload event, copy the shift register into a pending register and set pend; the copy takes the pre-shift value if an sclk event occurs in the same cycle.
REQ-014 SHALL clamp a latched value of 0 or 1 to 2 when it is written into the pending register.
REQ-015 SHALL set pend on the 3rd clk rising edge after sload rises, with setup met at the first edge.
REQ-016 SHALL run a down-counter cnt that reloads with div-1 when it is 0 and otherwise decrements by 1.
REQ-017 SHALL make the output period exactly div clk cycles.
REQ-018 SHALL register tc as (cnt == 0); tc is high for exactly 1 cycle per period.
REQ-019 SHALL register lo_out as (cnt >= div>>1), giving ceil(div/2) cycles high and floor(div/2) cycles low.
REQ-020 SHALL change lo_out only from a flop, so that it is glitch-free.
REQ-021 SHALL, when cnt == 0 and pend == 1, load div from the pending register, reload cnt with the new div-1 and clear pend in the same cycle.
REQ-022 SHALL keep the current period uninterrupted on a ratio change; the new ratio takes effect from the next period.
REQ-023 SHALL handle an sload event coinciding with cnt == 0 while pend == 1 as follows: the old pending value is applied, the new value overwrites the pending register, and pend stays 1.
REQ-024 SHALL overwrite the pending register on repeated sload events before terminal count; only the last value is applied.
REQ-025 SHALL shift the shift register freely without affecting div until an sload event occurs.

Reset
REQ-026 SHALL, while rst is high, hold the following values: div = RESET_DIV, cnt = RESET_DIV-1, shift and pending registers = 0, pend = 0, tc = 0, lo_out = 0, all synchronizer and history flops = 0.
REQ-027 SHALL resume counting from cnt = RESET_DIV-1 on the first clk edge after rst deasserts.
REQ-028 SHALL discard any partial serial word and any pending ratio when rst is asserted mid-operation; div returns to RESET_DIV.

Verification
REQ-029 SHALL cover: reset release with defaults -> lo_out period 4 clk cycles (2 high, 2 low); tc every 4th cycle.
REQ-030 SHALL cover: shift in 8'd7, pulse sload -> pend = 1 after 3 edges; at the next tc, period becomes 7 (4 high, 3 low); pend = 0.
REQ-031 SHALL cover: shift in 8'd1 and latch -> applied ratio is 2 (1 high, 1 low).
REQ-032 SHALL cover: latch 8'd10, then latch 8'd5 before tc -> only ratio 5 is applied (3 high, 2 low).
REQ-033 SHALL cover: sload event aligned to cnt == 0 with pend already set (pending = 6, new = 9) -> period 6 starts, pend stays 1, period 9 follows.
REQ-034 SHALL cover: assert rst mid-period with ratio 7 active and a word half shifted -> lo_out = 0 and tc = 0 immediately; after release, period 4 and pend = 0.

Source files
------------

// File: rtl/lo_prescaler.sv
// Programmable LO prescaler: serially loaded divide ratio and a down-counter.
// The counter produces a registered, glitch-free divided clock and a terminal-count pulse.
module lo_prescaler #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic sdata,
  input  logic sload,
  output logic lo_out,
  output logic tc,
  output logic pend
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  logic [1:0]       sclk_sync;
  logic [1:0]       sdata_sync;
  logic [1:0]       sload_sync;
  logic             sclk_hist;
  logic             sload_hist;
  logic             sclk_ev;
  logic             sload_ev;
  logic             apply;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] latched;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      sload_sync <= '0;
      sclk_hist  <= 1'b0;
      sload_hist <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk};
      sdata_sync <= {sdata_sync[0], sdata};
      sload_sync <= {sload_sync[0], sload};
      sclk_hist  <= sclk_sync[1];
      sload_hist <= sload_sync[1];
    end
  end

  assign sclk_ev  = sclk_sync[1] & ~sclk_hist;
  assign sload_ev = sload_sync[1] & ~sload_hist;
  assign apply    = (cnt == '0) && pend;

  always_comb begin
    latched = shift;
    if (shift < MIN_DIV) latched = MIN_DIV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift <= '0;
    end else if (sclk_ev) begin
      shift <= {shift[WIDTH-2:0], sdata_sync[1]};
    end
  end

  // A latch coinciding with an apply wins the pend flag: the old value is
  // consumed into div while the new one becomes the next pending ratio.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      pend    <= 1'b0;
    end else if (sload_ev) begin
      pending <= latched;
      pend    <= 1'b1;
    end else if (apply) begin
      pend    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= RST_DIV;
      cnt    <= RST_DIV - 1'b1;
      tc     <= 1'b0;
      lo_out <= 1'b0;
    end else begin
      tc     <= (cnt == '0);
      lo_out <= (cnt >= (div >> 1));
      if (cnt == '0) begin
        if (pend) begin
          div <= pending;
          cnt <= pending - 1'b1;
        end else begin
          cnt <= div - 1'b1;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule
